ts_adc_accumulator: RTL and testbench

Bit-serial shift-accumulator directly downstream of the ts_column macro. It takes the per-column ADC codes produced once per input bit-plane and weights each code by 2^plane. Over numInBits planes it builds one full-precision multi-bit MAC result per column. The result vector is presented to the next stage over a valid/ready handshake, with backpressure to the column sequencer.

---
 rtl/ts_adc_accumulator.sv | 97 +++++++++
 tb/tb_ts_adc_accumulator.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ts_adc_accumulator.sv
// Bit-serial shift-accumulator: weights per-column ADC codes by 2^plane and sums over numInBits
// planes. Define SIGNED_INPUT_EN to treat activations as two's complement (last plane subtracts).
module ts_adc_accumulator #(
  parameter int unsigned numCols    = 8,
  parameter int unsigned numAdcBits = 4,
  parameter int unsigned numInBits  = 4,
  parameter int unsigned accWidth   = 16,
  localparam int unsigned PlaneW    = $clog2(numInBits)
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           clear_i,
  input  logic [numAdcBits*numCols-1:0]  adc_data_i,
  input  logic                           adc_valid_i,
  output logic                           adc_ready_o,
  output logic [accWidth*numCols-1:0]    acc_data_o,
  output logic                           acc_valid_o,
  input  logic                           acc_ready_i,
  output logic [PlaneW-1:0]              plane_idx_o,
  output logic                           busy_o
);

  typedef enum logic [0:0] {StAcc, StOut} state_e;

  localparam logic [PlaneW-1:0] LastPlane = PlaneW'(numInBits - 1);

  state_e                                state_q, state_d;
  logic [PlaneW-1:0]                     plane_q, plane_d;
  logic                                  valid_q, valid_d;
  logic [numCols-1:0][accWidth-1:0]      acc_q, acc_d;
  logic                                  accept;
  logic [accWidth-1:0]                   term;

  assign adc_ready_o = !clear_i && ((state_q == StAcc) || acc_ready_i);
  assign accept      = adc_valid_i && adc_ready_o;

  always_comb begin
    state_d = state_q;
    plane_d = plane_q;
    valid_d = valid_q;
    acc_d   = acc_q;
    term    = '0;
    if (clear_i) begin
      // Abort keeps acc contents; the next plane 0 reloads them anyway.
      state_d = StAcc;
      plane_d = '0;
      valid_d = 1'b0;
    end else begin
      if ((state_q == StOut) && acc_ready_i) begin
        state_d = StAcc;
        valid_d = 1'b0;
      end
      if (accept) begin
        for (int j = 0; j < int'(numCols); j++) begin
          term = accWidth'(adc_data_i[j*numAdcBits +: numAdcBits]) << plane_q;
          if (plane_q == '0) begin
            acc_d[j] = term;
          end else begin
`ifdef SIGNED_INPUT_EN
            if (plane_q == LastPlane) acc_d[j] = acc_q[j] - term;
            else                      acc_d[j] = acc_q[j] + term;
`else
            acc_d[j] = acc_q[j] + term;
`endif
          end
        end
        if (plane_q == LastPlane) begin
          plane_d = '0;
          state_d = StOut;
          valid_d = 1'b1;
        end else begin
          plane_d = plane_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StAcc;
      plane_q <= '0;
      valid_q <= 1'b0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      plane_q <= plane_d;
      valid_q <= valid_d;
      acc_q   <= acc_d;
    end
  end

  assign acc_data_o  = acc_q;
  assign acc_valid_o = valid_q;
  assign plane_idx_o = plane_q;
  assign busy_o      = (state_q == StOut) || (plane_q != '0);

endmodule

// File: tb/tb_ts_adc_accumulator.sv
// Self-checking bench for ts_adc_accumulator; results are checked against a queue of expected
// vectors computed when each MAC's planes are driven.
module tb_ts_adc_accumulator;

  logic         CLK = 1'b0;
  logic         RST;
  logic         clear_i;
  logic [31:0]  adc_data_i;
  logic         adc_valid_i;
  logic         adc_ready_o;
  logic [127:0] acc_data_o;
  logic         acc_valid_o;
  logic         acc_ready_i;
  logic [1:0]   plane_idx_o;
  logic         busy_o;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  logic [127:0] exp_q[$];

  ts_adc_accumulator dut (
    .CLK         (CLK),
    .RST         (RST),
    .clear_i     (clear_i),
    .adc_data_i  (adc_data_i),
    .adc_valid_i (adc_valid_i),
    .adc_ready_o (adc_ready_o),
    .acc_data_o  (acc_data_o),
    .acc_valid_o (acc_valid_o),
    .acc_ready_i (acc_ready_i),
    .plane_idx_o (plane_idx_o),
    .busy_o      (busy_o)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Scoreboard: a result is consumed on the edge following a negedge with valid && ready.
  always @(negedge CLK) begin
    if (!RST && acc_valid_o && acc_ready_i) begin
      logic [127:0] e;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL result_unexpected got=%h", acc_data_o);
      end else begin
        e = exp_q.pop_front();
        if (acc_data_o !== e) begin
          fails++;
          $display("FAIL result got=%h exp=%h", acc_data_o, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] rep(input logic [3:0] c);
    return {8{c}};
  endfunction

  function automatic logic [127:0] model(input logic [31:0] p0, p1, p2, p3);
    logic [127:0] r;
    logic [31:0]  p [4];
    logic [15:0]  a, t;
    p[0] = p0; p[1] = p1; p[2] = p2; p[3] = p3;
    for (int c = 0; c < 8; c++) begin
      a = '0;
      for (int k = 0; k < 4; k++) begin
        t = {12'd0, p[k][c*4 +: 4]} << k;
`ifdef SIGNED_INPUT_EN
        if (k == 3) a = a - t;
        else        a = a + t;
`else
        a = a + t;
`endif
      end
      r[c*16 +: 16] = a;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic beat(input logic [31:0] d);
    int n;
    adc_valid_i = 1'b1;
    adc_data_i  = d;
    n = 0;
    #0;
    while (!adc_ready_o && n < 50) begin
      tick();
      n++;
    end
    tests++;
    if (n >= 50) begin
      fails++;
      $display("FAIL beat_wait got=ready0 exp=ready1");
    end
    tick();
    adc_valid_i = 1'b0;
  endtask

  task automatic mac(input logic [31:0] p0, p1, p2, p3);
    exp_q.push_back(model(p0, p1, p2, p3));
    beat(p0); beat(p1); beat(p2); beat(p3);
  endtask

  task automatic test_reset();
    RST = 1'b1; clear_i = 1'b0; adc_valid_i = 1'b0; adc_data_i = '0; acc_ready_i = 1'b1;
    tick(); tick();
    RST = 1'b0;
    tick();
    tests++; if (acc_valid_o !== 1'b0) begin fails++; $display("FAIL rst_valid got=%b exp=0", acc_valid_o); end
    tests++; if (plane_idx_o !== 2'd0) begin fails++; $display("FAIL rst_plane got=%0d exp=0", plane_idx_o); end
    tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL rst_busy got=%b exp=0", busy_o); end
    tests++; if (acc_data_o !== '0) begin fails++; $display("FAIL rst_data got=%h exp=0", acc_data_o); end
    tests++; if (adc_ready_o !== 1'b1) begin fails++; $display("FAIL rst_ready got=%b exp=1", adc_ready_o); end
  endtask

  task automatic test_basic();
    logic [15:0] e;
`ifdef SIGNED_INPUT_EN
    e = 16'hFFFD;
`else
    e = 16'h002D;
`endif
    acc_ready_i = 1'b1;
    mac(rep(4'd3), rep(4'd3), rep(4'd3), rep(4'd3));
    tests++; if (acc_valid_o !== 1'b1) begin fails++; $display("FAIL basic_valid got=%b exp=1", acc_valid_o); end
    tests++; if (acc_data_o[16*7 +: 16] !== e) begin
      fails++; $display("FAIL basic_col7 got=%h exp=%h", acc_data_o[16*7 +: 16], e);
    end
    tick();
    tests++; if (acc_valid_o !== 1'b0) begin fails++; $display("FAIL basic_drop got=%b exp=0", acc_valid_o); end
  endtask

  task automatic test_plane3_only();
    logic [15:0] e;
`ifdef SIGNED_INPUT_EN
    e = 16'hFF88;
`else
    e = 16'h0078;
`endif
    mac(rep(4'd0), rep(4'd0), rep(4'd0), rep(4'd15));
    tests++; if (acc_data_o[0 +: 16] !== e) begin
      fails++; $display("FAIL plane3_col0 got=%h exp=%h", acc_data_o[0 +: 16], e);
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [127:0] held;
    logic [15:0]  e;
`ifdef SIGNED_INPUT_EN
    e = 16'hFFFB;
`else
    e = 16'd75;
`endif
    acc_ready_i = 1'b0;
    mac(32'h76543210, 32'h76543210, 32'h76543210, 32'h76543210);
    held = acc_data_o;
    tests++; if (held[16*5 +: 16] !== e) begin
      fails++; $display("FAIL bp_col5 got=%h exp=%h", held[16*5 +: 16], e);
    end
    adc_valid_i = 1'b1; adc_data_i = rep(4'd9);
    for (int i = 0; i < 5; i++) begin
      #1;
      tests++;
      if (acc_valid_o !== 1'b1 || acc_data_o !== held || adc_ready_o !== 1'b0 || busy_o !== 1'b1) begin
        fails++;
        $display("FAIL bp_hold cyc%0d got=v%b r%b d%h exp=v1 r0 d%h", i, acc_valid_o, adc_ready_o,
                 acc_data_o, held);
      end
      tick();
    end
    adc_valid_i = 1'b0;
    acc_ready_i = 1'b1;
    #1;
    tests++; if (adc_ready_o !== 1'b1) begin fails++; $display("FAIL bp_release got=%b exp=1", adc_ready_o); end
    tick();
    tests++; if (acc_valid_o !== 1'b0) begin fails++; $display("FAIL bp_drop got=%b exp=0", acc_valid_o); end
  endtask

  task automatic test_back_to_back();
    int start;
    acc_ready_i = 1'b1;
    start = cyc;
    mac(rep(4'd15), rep(4'd15), rep(4'd15), rep(4'd15));
    tests++; if (acc_valid_o !== 1'b1) begin fails++; $display("FAIL b2b_valid1 got=%b exp=1", acc_valid_o); end
    mac(rep(4'd1), rep(4'd1), rep(4'd1), rep(4'd1));
    tests++; if (cyc - start !== 8) begin fails++; $display("FAIL b2b_cycles got=%0d exp=8", cyc - start); end
    tests++; if (acc_valid_o !== 1'b1) begin fails++; $display("FAIL b2b_valid2 got=%b exp=1", acc_valid_o); end
    tick();
  endtask

  task automatic test_clear();
    beat(rep(4'd7)); beat(rep(4'd7));
    tests++; if (plane_idx_o !== 2'd2) begin fails++; $display("FAIL clr_pre got=%0d exp=2", plane_idx_o); end
    clear_i = 1'b1; adc_valid_i = 1'b1; adc_data_i = rep(4'd7);
    #1;
    tests++; if (adc_ready_o !== 1'b0) begin fails++; $display("FAIL clr_ready got=%b exp=0", adc_ready_o); end
    tick();
    clear_i = 1'b0; adc_valid_i = 1'b0;
    tests++; if (plane_idx_o !== 2'd0 || busy_o !== 1'b0) begin
      fails++; $display("FAIL clr_plane got=%0d/%b exp=0/0", plane_idx_o, busy_o);
    end
    mac(rep(4'd2), rep(4'd2), rep(4'd2), rep(4'd2));
    tick();
  endtask

  task automatic test_rst_mid();
    beat(rep(4'd15)); beat(rep(4'd15)); beat(rep(4'd15));
    tests++; if (plane_idx_o !== 2'd3 || busy_o !== 1'b1) begin
      fails++; $display("FAIL rstm_pre got=%0d/%b exp=3/1", plane_idx_o, busy_o);
    end
    RST = 1'b1;
    #1;
    tests++;
    if (acc_valid_o !== 1'b0 || plane_idx_o !== 2'd0 || busy_o !== 1'b0 || acc_data_o !== '0) begin
      fails++;
      $display("FAIL rstm_out got=v%b p%0d b%b d%h exp=v0 p0 b0 d0", acc_valid_o, plane_idx_o, busy_o,
               acc_data_o);
    end
    tick();
    RST = 1'b0;
    tick();
    mac(rep(4'd1), rep(4'd1), rep(4'd1), rep(4'd1));
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_plane3_only();
    test_backpressure();
    test_back_to_back();
    test_clear();
    test_rst_mid();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
